// File: rtl/pool2x2_param_layer.sv
// 2x2 pooling layer (signed max / floor average) over CH packed channels.
// Walks an out_dim x out_dim output frame in raster order: one window read per cycle, one save two cycles later.
module pool2x2_param_layer #(
  parameter int CH = 8,
  parameter int DW = 16,
  parameter int AW = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [AW-1:0]    out_dim,
  input  logic             pool_mode,
  input  logic             hold,
  input  logic [CH*DW-1:0] in_ee,
  input  logic [CH*DW-1:0] in_eo,
  input  logic [CH*DW-1:0] in_oe,
  input  logic [CH*DW-1:0] in_oo,
  output logic             rd_en,
  output logic [AW-1:0]    rd_row,
  output logic [AW-1:0]    rd_col,
  output logic             save_en,
  output logic [AW-1:0]    out_row,
  output logic [AW-1:0]    out_col,
  output logic [CH*DW-1:0] out_data,
  output logic             row_done,
  output logic             done,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;

  logic [AW-1:0]    r_dim;
  logic             r_mode;
  logic [AW-1:0]    r_rd_row;
  logic [AW-1:0]    r_rd_col;

  logic             r_v1;
  logic [AW-1:0]    r_row1;
  logic [AW-1:0]    r_col1;
  logic             r_v2;
  logic [AW-1:0]    r_row2;
  logic [AW-1:0]    r_col2;
  logic [CH*DW-1:0] r_data;

  logic             w_start_ok;
  logic [AW-1:0]    w_dim_m1;
  logic             w_col_last;
  logic             w_rd_last;
  logic             w_rd_en;
  logic             w_busy;
  logic             w_row_done;
  logic             w_done;
  logic [CH*DW-1:0] w_pool;

  // Sum is sign-extended to DW+2 bits so four extreme values cannot overflow.
  function automatic logic [DW-1:0] pool_ch(
    input logic signed [DW-1:0] a,
    input logic signed [DW-1:0] b,
    input logic signed [DW-1:0] c,
    input logic signed [DW-1:0] d,
    input logic                 avg
  );
    logic signed [DW-1:0] m0;
    logic signed [DW-1:0] m1;
    logic signed [DW+1:0] s;
    m0 = (a > b) ? a : b;
    m1 = (c > d) ? c : d;
    s  = {{2{a[DW-1]}}, a} + {{2{b[DW-1]}}, b} + {{2{c[DW-1]}}, c} + {{2{d[DW-1]}}, d};
    if (avg) return DW'(s >>> 2);
    return (m0 > m1) ? m0 : m1;
  endfunction

  assign w_start_ok = start && (out_dim != '0);
  assign w_dim_m1   = r_dim - AW'(1);
  assign w_col_last = (r_rd_col == w_dim_m1);
  assign w_rd_last  = w_col_last && (r_rd_row == w_dim_m1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start_ok) w_next = S_RUN;
      S_RUN:   if (w_rd_en && w_rd_last) w_next = S_DRAIN;
      S_DRAIN: if (w_done) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_rd_en = 1'b0;
    w_busy  = 1'b0;
    case (r_state)
      S_RUN: begin
        w_rd_en = ~hold;
        w_busy  = 1'b1;
      end
      S_DRAIN: w_busy = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dim  <= '0;
      r_mode <= 1'b0;
    end else if (r_state == S_IDLE && w_start_ok) begin
      r_dim  <= out_dim;
      r_mode <= pool_mode;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_row <= '0;
      r_rd_col <= '0;
    end else if (r_state == S_IDLE && w_start_ok) begin
      r_rd_row <= '0;
      r_rd_col <= '0;
    end else if (w_rd_en) begin
      if (w_col_last) begin
        r_rd_col <= '0;
        r_rd_row <= w_rd_last ? '0 : r_rd_row + AW'(1);
      end else begin
        r_rd_col <= r_rd_col + AW'(1);
      end
    end
  end

  always_comb begin
    w_pool = '0;
    for (int unsigned k = 0; k < CH; k++) begin
      w_pool[k*DW +: DW] = pool_ch(in_ee[k*DW +: DW], in_eo[k*DW +: DW],
                                   in_oe[k*DW +: DW], in_oo[k*DW +: DW], r_mode);
    end
  end

  // The pipeline never stalls: hold only suppresses new reads, which become bubbles here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1   <= 1'b0;
      r_row1 <= '0;
      r_col1 <= '0;
      r_v2   <= 1'b0;
      r_row2 <= '0;
      r_col2 <= '0;
      r_data <= '0;
    end else begin
      r_v1 <= w_rd_en;
      if (w_rd_en) begin
        r_row1 <= r_rd_row;
        r_col1 <= r_rd_col;
      end
      r_v2 <= r_v1;
      if (r_v1) begin
        r_row2 <= r_row1;
        r_col2 <= r_col1;
        r_data <= w_pool;
      end
    end
  end

  assign w_row_done = r_v2 && (r_col2 == w_dim_m1);
  assign w_done     = w_row_done && (r_row2 == w_dim_m1);

  assign rd_en    = w_rd_en;
  assign rd_row   = r_rd_row;
  assign rd_col   = r_rd_col;
  assign save_en  = r_v2;
  assign out_row  = r_row2;
  assign out_col  = r_col2;
  assign out_data = r_data;
  assign row_done = w_row_done;
  assign done     = w_done;
  assign busy     = w_busy;

endmodule

// File: tb/tb_pool2x2_param_layer.sv
// Scoreboard bench for pool2x2_param_layer: reads are checked against a raster model,
// expected saves are queued at read time and popped when save_en appears.
module tb_pool2x2_param_layer;

  localparam int CH = 8;
  localparam int DW = 16;
  localparam int AW = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [AW-1:0]    out_dim;
  logic             pool_mode;
  logic             hold;
  logic [CH*DW-1:0] in_ee, in_eo, in_oe, in_oo;
  logic             rd_en;
  logic [AW-1:0]    rd_row, rd_col;
  logic             save_en;
  logic [AW-1:0]    out_row, out_col;
  logic [CH*DW-1:0] out_data;
  logic             row_done, done, busy;

  typedef struct {
    logic [CH*DW-1:0] ee, eo, oe, oo;
    logic             dir;
    logic [DW-1:0]    dval;
  } win_t;

  typedef struct {
    logic [AW-1:0]    r, c;
    logic [CH*DW-1:0] d;
    logic             rdn, dn;
    int               cyc;
    logic             dir;
    logic [DW-1:0]    dval;
  } exp_t;

  exp_t sb[$];
  win_t dq[$];

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int n_reads = 0;
  int n_saves = 0;
  int n_rowdone = 0;
  int last_rd_cyc = 0;
  int frame_dim = 1;
  logic frame_mode = 1'b0;

  pool2x2_param_layer #(.CH(CH), .DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .out_dim(out_dim), .pool_mode(pool_mode),
    .hold(hold), .in_ee(in_ee), .in_eo(in_eo), .in_oe(in_oe), .in_oo(in_oo),
    .rd_en(rd_en), .rd_row(rd_row), .rd_col(rd_col), .save_en(save_en),
    .out_row(out_row), .out_col(out_col), .out_data(out_data),
    .row_done(row_done), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic logic [CH*DW-1:0] rnd_vec();
    logic [CH*DW-1:0] v;
    for (int k = 0; k < CH; k++) begin
      case ($urandom_range(0, 5))
        0:       v[k*DW +: DW] = 16'h7FFF;
        1:       v[k*DW +: DW] = 16'h8000;
        default: v[k*DW +: DW] = DW'($urandom);
      endcase
    end
    return v;
  endfunction

  function automatic logic [CH*DW-1:0] model(input win_t w, input logic avg);
    logic [CH*DW-1:0] r;
    int a, b, c, d, m, s;
    for (int k = 0; k < CH; k++) begin
      a = $signed(w.ee[k*DW +: DW]);
      b = $signed(w.eo[k*DW +: DW]);
      c = $signed(w.oe[k*DW +: DW]);
      d = $signed(w.oo[k*DW +: DW]);
      if (avg) begin
        s = (a + b + c + d) >>> 2;
        r[k*DW +: DW] = s[DW-1:0];
      end else begin
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        r[k*DW +: DW] = m[DW-1:0];
      end
    end
    return r;
  endfunction

  // Monitor / window driver / scoreboard
  initial begin
    logic [AW-1:0]    er, ec;
    logic [CH*DW-1:0] exp_last;
    win_t             pend, w;
    logic             have_pend;
    exp_t             e;
    er = '0; ec = '0; exp_last = '0; have_pend = 1'b0;
    in_ee = '0; in_eo = '0; in_oe = '0; in_oo = '0;
    forever begin
      @(negedge clk);
      cyc++;
      have_pend = 1'b0;
      if (rst) begin
        sb.delete();
        er = '0; ec = '0; exp_last = '0;
      end else begin
        if (hold) chk("rd_during_hold", rd_en, 1'b0);
        if (rd_en) begin
          chk("rd_addr", {rd_row, rd_col}, {er, ec});
          if (dq.size() > 0) w = dq.pop_front();
          else begin
            w.ee = rnd_vec(); w.eo = rnd_vec(); w.oe = rnd_vec(); w.oo = rnd_vec();
            w.dir = 1'b0; w.dval = '0;
          end
          e.r = er; e.c = ec; e.d = model(w, frame_mode);
          e.rdn = (ec == AW'(frame_dim - 1));
          e.dn  = e.rdn && (er == AW'(frame_dim - 1));
          e.cyc = cyc; e.dir = w.dir; e.dval = w.dval;
          sb.push_back(e);
          pend = w; have_pend = 1'b1;
          n_reads++; last_rd_cyc = cyc;
          if (ec == AW'(frame_dim - 1)) begin
            ec = '0;
            er = (er == AW'(frame_dim - 1)) ? '0 : er + 1'b1;
          end else ec = ec + 1'b1;
        end
        if (save_en) begin
          n_saves++;
          if (row_done) n_rowdone++;
          if (sb.size() == 0) chk("save_unexpected", save_en, 1'b0);
          else begin
            e = sb.pop_front();
            chk("save_addr", {out_row, out_col}, {e.r, e.c});
            chk("save_data", out_data, e.d);
            chk("save_flags", {row_done, done}, {e.rdn, e.dn});
            chk("save_latency", cyc, e.cyc + 2);
            if (e.dir) chk("avg_ch0", out_data[DW-1:0], e.dval);
            exp_last = e.d;
          end
        end else begin
          chk("flags_no_save", {row_done, done}, 2'b00);
          chk("data_hold", out_data, exp_last);
        end
      end
      @(posedge clk); #1;
      if (have_pend) begin
        in_ee = pend.ee; in_eo = pend.eo; in_oe = pend.oe; in_oo = pend.oo;
      end else begin
        in_ee = rnd_vec(); in_eo = rnd_vec(); in_oe = rnd_vec(); in_oo = rnd_vec();
      end
    end
  end

  // Caller must be at posedge+1; returns at posedge+1 of the cycle after done.
  task automatic run_frame(input int dim, input logic mode, input logic hold_alt, input logic poke);
    int c0, r0, s0, rd0, k, span;
    logic got;
    start = 1'b1; out_dim = AW'(dim); pool_mode = mode;
    frame_dim = dim; frame_mode = mode;
    r0 = n_reads; s0 = n_saves; rd0 = n_rowdone;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", busy, 1'b1);
    c0 = cyc; k = 0; got = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); #2;
      if (done) begin got = 1'b1; break; end
      @(posedge clk); #1;
      k++;
      hold = hold_alt && (k % 2 == 1);
      if (poke && k == 3) begin
        start = 1'b1; out_dim = AW'(7); pool_mode = ~mode;
      end else start = 1'b0;
    end
    hold = 1'b0; start = 1'b0;
    chk("done_seen", got, 1'b1);
    @(posedge clk); #1;
    chk("busy_after_done", busy, 1'b0);
    span = hold_alt ? 2 * (dim * dim - 1) : dim * dim - 1;
    chk("read_count", n_reads - r0, dim * dim);
    chk("save_count", n_saves - s0, dim * dim);
    chk("row_done_count", n_rowdone - rd0, dim);
    chk("last_read_cycle", last_rd_cyc, c0 + 1 + span);
    chk("sb_empty", sb.size(), 0);
  endtask

  function automatic win_t dwin(input logic [DW-1:0] a, b, c, d, input logic [DW-1:0] res);
    win_t w;
    w.ee = rnd_vec(); w.eo = rnd_vec(); w.oe = rnd_vec(); w.oo = rnd_vec();
    w.ee[DW-1:0] = a; w.eo[DW-1:0] = b; w.oe[DW-1:0] = c; w.oo[DW-1:0] = d;
    w.dir = 1'b1; w.dval = res;
    return w;
  endfunction

  initial begin
    int r0, s0;
    logic got;
    rst = 1'b1; start = 1'b0; out_dim = '0; pool_mode = 1'b0; hold = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_outputs", {rd_en, save_en, row_done, done, busy, rd_row, rd_col, out_row, out_col, out_data}, '0);
    @(posedge clk); #1;
    rst = 1'b0;

    // max mode, no hold
    run_frame(4, 1'b0, 1'b0, 1'b0);

    // average mode directed corner values on channel 0
    dq.push_back(dwin(16'hFFFF, 16'hFFFE, 16'hFFFE, 16'hFFFE, 16'hFFFE));
    dq.push_back(dwin(16'h0003, 16'h0003, 16'h0003, 16'h0002, 16'h0002));
    dq.push_back(dwin(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF));
    dq.push_back(dwin(16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000));
    run_frame(2, 1'b1, 1'b0, 1'b0);
    chk("directed_consumed", dq.size(), 0);

    // hold on every second RUN cycle
    run_frame(3, 1'b0, 1'b1, 1'b0);

    // single-pixel frame
    run_frame(1, 1'b1, 1'b0, 1'b0);

    // zero-dimension start is ignored
    r0 = n_reads;
    start = 1'b1; out_dim = '0;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_dim0", busy, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("busy_dim0_later", busy, 1'b0);
    chk("reads_dim0", n_reads - r0, 0);

    // reset at the 5th save aborts the frame
    start = 1'b1; out_dim = AW'(4); pool_mode = 1'b0; frame_dim = 4; frame_mode = 1'b0;
    s0 = n_saves;
    @(posedge clk); #1;
    start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk); #2;
      if (n_saves - s0 == 5) begin got = 1'b1; break; end
    end
    chk("fifth_save_seen", got, 1'b1);
    rst = 1'b1;
    #1;
    chk("abort_outputs", {rd_en, save_en, row_done, done, busy, rd_row, rd_col, out_row, out_col, out_data}, '0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_frame(2, 1'b0, 1'b0, 1'b0);

    // start/config poke during RUN, then back-to-back frame
    run_frame(3, 1'b0, 1'b0, 1'b1);
    run_frame(3, 1'b1, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", n_chk);
    $fatal(1);
  end

endmodule
